// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles every bus signal around the data-memory arbiter: the two requester
//   ports, the shared read-return path, the CPU stall and the single-port
//   memory command/response.
//   slave  : the arbiter's view (requests and mem_rdata in; grants, read
//            return, stall and memory command out).
//   master : the surrounding system's view (requesters plus memory instance).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // port 0: CPU load/store path
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  // port 1: debug / program-loader master
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              lock1;
  logic              gnt1;
  logic              rvalid1;
  // shared return path and CPU stall
  logic [DATA_W-1:0] rdata;
  logic              cpu_stall;
  // memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1, lock1,
    input  mem_rdata,
    output gnt0, rvalid0, gnt1, rvalid1, rdata, cpu_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1, lock1,
    output mem_rdata,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata, cpu_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port data memory between the CPU (port 0) and a debug /
//   loader master (port 1). One memory command per clock, round-robin between
//   the ports, with a bounded lock that lets port 1 burst for up to MAX_LOCK
//   consecutive beats before port 0 is forced in for one beat.
// Ports
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-high; forces all grants/strobes/valids low
//   bus   : dmem_arbiter_if.slave -- requests, combinational grants,
//           registered rvalid per port, shared rdata, cpu_stall and the
//           memory command/response
module dmem_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MAX_LOCK = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  port_e             last_gnt_r, last_gnt_nxt_s;
  logic              locked_r, locked_nxt_s;
  logic [CNT_W-1:0]  lock_cnt_r, lock_cnt_nxt_s;
  logic [1:0]        rd_pend_r, rd_pend_nxt_s;
  logic              gnt0_s, gnt1_s, at_limit_s;
  logic [ADDR_W-1:0] addr_mux_s;
  logic [DATA_W-1:0] wdata_mux_s;

  // Winner selection: lock ownership first, then round-robin on contention
  always_comb begin
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    at_limit_s = (lock_cnt_r == CNT_MAX);
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (locked_r && bus.req1) begin
      // burst budget spent and CPU waiting: one forced yield beat
      if (at_limit_s && bus.req0) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else if (bus.req0 && bus.req1) begin
      if (last_gnt_r == PORT0) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b1;
      end
    end else begin
      // single requester (or locked owner gone quiet: req1 is 0 here)
      gnt0_s = bus.req0;
      gnt1_s = bus.req1;
    end
  end

  // Next-state for ownership history, lock tracking and read-return flags
  always_comb begin
    last_gnt_nxt_s = last_gnt_r;
    locked_nxt_s   = locked_r;
    lock_cnt_nxt_s = lock_cnt_r;
    rd_pend_nxt_s  = {gnt1_s & ~bus.we1, gnt0_s & ~bus.we0};
    if (gnt1_s) begin
      last_gnt_nxt_s = PORT1;
      if (bus.lock1) begin
        locked_nxt_s = 1'b1;
        if (!at_limit_s) begin
          lock_cnt_nxt_s = lock_cnt_r + CNT_ONE;
        end else begin
          lock_cnt_nxt_s = lock_cnt_r;
        end
      end else begin
        locked_nxt_s   = 1'b0;
        lock_cnt_nxt_s = CNT_ZERO;
      end
    end else if (locked_r && !bus.req1) begin
      // owner abandoned the lock
      locked_nxt_s   = 1'b0;
      lock_cnt_nxt_s = CNT_ZERO;
      if (gnt0_s) begin
        last_gnt_nxt_s = PORT0;
      end else begin
        last_gnt_nxt_s = last_gnt_r;
      end
    end else if (gnt0_s) begin
      // either unlocked (count already zero) or the forced yield, which
      // restarts port 1's burst budget while keeping the lock
      last_gnt_nxt_s = PORT0;
      lock_cnt_nxt_s = CNT_ZERO;
    end else begin
      last_gnt_nxt_s = last_gnt_r;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt_r <= PORT1;
      locked_r   <= 1'b0;
      lock_cnt_r <= CNT_ZERO;
      rd_pend_r  <= 2'b00;
    end else begin
      last_gnt_r <= last_gnt_nxt_s;
      locked_r   <= locked_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
      rd_pend_r  <= rd_pend_nxt_s;
    end
  end

  // Command mux, grants, stall and read return
  always_comb begin
    if (gnt1_s) begin
      bus.mem_we  = bus.we1;
      addr_mux_s  = bus.addr1;
      wdata_mux_s = bus.wdata1;
    end else if (gnt0_s) begin
      bus.mem_we  = bus.we0;
      addr_mux_s  = bus.addr0;
      wdata_mux_s = bus.wdata0;
    end else begin
      bus.mem_we  = 1'b0;
      addr_mux_s  = bus.addr0;
      wdata_mux_s = bus.wdata0;
    end
    bus.mem_addr  = addr_mux_s;
    bus.mem_wdata = wdata_mux_s;
    bus.gnt0      = gnt0_s;
    bus.gnt1      = gnt1_s;
    bus.mem_en    = gnt0_s | gnt1_s;
    bus.cpu_stall = bus.req0 & ~gnt0_s & ~reset;
    bus.rvalid0   = rd_pend_r[0];
    bus.rvalid1   = rd_pend_r[1];
    bus.rdata     = bus.mem_rdata;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between two requesters: the CPU load/store path (port 0) and a debug/program-loader master (port 1). The arbiter issues at most one memory command per clock. Arbitration is round-robin with a bounded lock that lets port 1 perform burst accesses. It also returns read data with a one-cycle `rvalid` and drives a CPU stall signal whenever port 0 is denied. It sits between the CPU datapath's memory interface and the data memory instance.

## Interface
- `ADDR_W`, 64: address width for both ports and the memory.
- `DATA_W`, 64: data width.
- `MAX_LOCK`, 4: maximum consecutive locked port-1 grants while port 0 waits. Legal range is 1..255.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req0` / `req1` in 1: access request. The requester holds it, with stable attributes, until granted.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in ADDR_W: byte address.
- `wdata0` / `wdata1` in DATA_W: write data.
- `lock1` in 1: port 1 requests that the arbiter keep ownership after this beat.
- `gnt0` / `gnt1` out 1: combinational grant, valid in the same cycle as the request.
- `rvalid0` / `rvalid1` out 1: registered; the read data for that port is valid this cycle.
- `rdata` out DATA_W: shared read data, equal to `mem_rdata`.
- `cpu_stall` out 1: equals `req0 & ~gnt0`.
- `mem_en`, `mem_we` out 1: memory command strobe and write enable.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: memory command attributes.
- `mem_rdata` in DATA_W: memory read data, registered by the memory and valid the cycle after a read command.

## Operation
- State registers:
  - `last_gnt`: the port granted most recently. Resets to 1.
  - `locked`: port 1 owns the memory. Resets to 0.
  - `lock_cnt`: count of locked beats, width clog2(MAX_LOCK+1). Resets to 0.
  - `rd_pend[1:0]`: which port, if any, has a read in flight. Resets to 0.
- Winner selection, evaluated each cycle while `reset` is low:
  - No request: no grant. `mem_en=0`. State is held, except that `locked` clears if `req1=0`.
  - One request, with `locked=0`: that port wins.
  - `locked=1`, `req1=1`, and `lock_cnt < MAX_LOCK`: port 1 wins regardless of `req0`.
  - `locked=1`, `lock_cnt == MAX_LOCK`, and `req0=1`: port 0 wins this cycle (the forced yield) and `lock_cnt` clears. `locked` stays 1, so port 1 resumes next cycle.
  - `locked=1`, `lock_cnt == MAX_LOCK`, and `req0=0`: port 1 wins and `lock_cnt` stays saturated.
  - Both requesting with `locked=0`: the port that is not `last_gnt` wins.
- On a grant:
  - `gnt_i=1` and `mem_en=1`.
  - `mem_we`, `mem_addr` and `mem_wdata` are muxed from the winner.
  - `last_gnt` updates to the winner.
- When nothing is granted, `mem_we=0`, and `mem_addr`/`mem_wdata` are driven by port 0 (don't care).
- Lock tracking:
  - A port-1 grant with `lock1=1` sets `locked` and increments `lock_cnt` (saturating at MAX_LOCK).
  - A port-1 grant with `lock1=0` clears both `locked` and `lock_cnt`.
  - `req1=0` while `locked=1` clears both `locked` and `lock_cnt`.
- Read return:
  - A granted read sets `rd_pend[i]` for one cycle.
  - `rvalid_i = rd_pend[i]`, and `rdata` carries `mem_rdata`.
  - Writes produce no `rvalid`.
- Reads and writes issued back-to-back are legal. A write followed by a read to the same address returns the new data; this is the memory's responsibility.

## Timing
- Grant latency is 0 cycles (combinational from `req`). Read-data latency is 1 cycle after the grant. Throughput is 1 access per cycle.
- While `reset=1`, all outputs are 0: `gnt0`, `gnt1`, `mem_en`, `mem_we`, `rvalid0`, `rvalid1` and `cpu_stall`.
- Reset asserted mid-read cancels the pending `rvalid`. Reset asserted mid-lock drops the lock.
- After `reset` deasserts, the first contended cycle grants port 0, because `last_gnt` resets to 1.
- Both requesters continuously active, `lock1=1`, MAX_LOCK=4: grant sequence 1,1,1,1,0,1,1,1,1,0,…
- Both active, `lock1=0`: grants strictly alternate 0,1,0,1.
- `req1` dropping while locked: in that same cycle port 0 wins if requesting, and the lock is cleared at the following edge.
- `cpu_stall` is purely combinational and never registered.

## Test plan
- **Reset behaviour.** Hold `reset=1` with both `req` high → all outputs 0. Release reset with both requesting (reads) → `gnt0` in cycle 0, `gnt1` in cycle 1, `rvalid0` in cycle 1, `rvalid1` in cycle 2.
- **Round-robin with stall.** Both ports request reads continuously, `lock1=0`, for 8 cycles → grants alternate 0,1,0,1,0,1,0,1. `cpu_stall=1` on exactly the 4 port-1 cycles.
- **Lock bound.** MAX_LOCK=4, `req0=1` throughout, port 1 burst of 10 writes with `lock1=1` → grant sequence 1,1,1,1,0,1,1,1,1,0,1,1. Every write appears on `mem_we`/`mem_addr` in order.
- **Lock release.** Port 1 has `lock1=1` for 2 beats and `lock1=0` on the 3rd; `req0` pending → port 0 is granted on the 4th cycle. `locked` and `lock_cnt` are 0 afterwards.
- **Reset during a lock.** Assert `reset` asynchronously while `locked=1` and a read is in flight → `rvalid` never asserts. After release, contended arbitration starts with port 0.
- **Single requester.** Port 0 alone writes addr 0x10 = 0xDEAD, then reads 0x10 → grants in consecutive cycles. `rvalid0=1` one cycle after the read grant, with `rdata=0xDEAD`. `cpu_stall` stays 0.
